// File: rtl/mem_ctrl.sv
// Load/store unit to word-wide memory bridge: byte/halfword lane handling, read-modify-write
// for sub-word stores, per-phase ack timeout. Optional misalignment trap: MEM_MISALIGN_CHK_EN.

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef MEM_OP_WIDTH
`define MEM_OP_WIDTH 4
`define MEM_LB  4'h0
`define MEM_LH  4'h1
`define MEM_LW  4'h2
`define MEM_LBU 4'h4
`define MEM_LHU 4'h5
`define MEM_SB  4'h8
`define MEM_SH  4'h9
`define MEM_SW  4'hA
`endif

// state | meaning
// IDLE  | waiting for lsu_req, operands latched on accept
// RD    | word read in flight (loads, and the read half of SB/SH)
// WR    | word write in flight (SW, or merged word of SB/SH)
// RESP  | access finished; done/err/rdata registered on the way out
module mem_ctrl #(
    parameter int WAIT_MAX = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     lsu_req,
    input  logic [`MEM_OP_WIDTH-1:0] lsu_op,
    input  logic [`CPU_WIDTH-1:0]    lsu_addr,
    input  logic [`CPU_WIDTH-1:0]    lsu_wdata,
    output logic [`CPU_WIDTH-1:0]    lsu_rdata,
    output logic                     lsu_done,
    output logic                     lsu_busy,
    output logic                     lsu_err,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [`CPU_WIDTH-1:0]    mem_addr,
    output logic [`CPU_WIDTH-1:0]    mem_wdata,
    input  logic [`CPU_WIDTH-1:0]    mem_rdata,
    input  logic                     mem_ack
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [`MEM_OP_WIDTH-1:0]   r_op;
    logic [1:0]                 r_addr_lo;
    logic [15:0]                r_wdata;
    logic [`CPU_WIDTH-1:0]      r_rd_word;
    logic [CW-1:0]              r_cnt;
    logic                       r_fail;
    logic                       r_mem_req;
    logic                       r_mem_we;
    logic [`CPU_WIDTH-1:0]      r_mem_addr;
    logic [`CPU_WIDTH-1:0]      r_mem_wdata;
    logic [`CPU_WIDTH-1:0]      r_lsu_rdata;
    logic                       r_lsu_done;
    logic                       r_lsu_busy;
    logic                       r_lsu_err;

    logic                       w_misalign;
    logic                       w_timeout;
    logic [`CPU_WIDTH-1:0]      w_merge;
    logic [`CPU_WIDTH-1:0]      w_load;
    logic [7:0]                 w_byte;
    logic [15:0]                w_half;

`ifdef MEM_MISALIGN_CHK_EN
    assign w_misalign = (lsu_op[1:0] == 2'd1) ? lsu_addr[0] :
                        (lsu_op[1:0] == 2'd2) ? (lsu_addr[1:0] != 2'b00) : 1'b0;
`else
    assign w_misalign = 1'b0;
`endif

    // Last cycle of the wait window; an ack in that same cycle still wins.
    assign w_timeout = (r_cnt == CW'(WAIT_MAX - 1)) && !mem_ack;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (lsu_req) begin
                    if (w_misalign)
                        w_next = RESP;
                    else if (lsu_op[3] && lsu_op[1])
                        w_next = WR;
                    else
                        w_next = RD;
                end
            end
            RD: begin
                if (mem_ack)
                    w_next = r_op[3] ? WR : RESP;
                else if (w_timeout)
                    w_next = RESP;
            end
            WR: begin
                if (mem_ack || w_timeout)
                    w_next = RESP;
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_merge = mem_rdata;
        if (r_op[0]) begin
            if (r_addr_lo[1])
                w_merge[31:16] = r_wdata[15:0];
            else
                w_merge[15:0] = r_wdata[15:0];
        end else begin
            w_merge[{r_addr_lo, 3'b000} +: 8] = r_wdata[7:0];
        end
    end

    always_comb begin
        w_byte = r_rd_word[{r_addr_lo, 3'b000} +: 8];
        w_half = r_addr_lo[1] ? r_rd_word[31:16] : r_rd_word[15:0];
        case (r_op[1:0])
            2'd0:    w_load = r_op[2] ? {{(`CPU_WIDTH-8){1'b0}}, w_byte}
                                      : {{(`CPU_WIDTH-8){w_byte[7]}}, w_byte};
            2'd1:    w_load = r_op[2] ? {{(`CPU_WIDTH-16){1'b0}}, w_half}
                                      : {{(`CPU_WIDTH-16){w_half[15]}}, w_half};
            default: w_load = r_rd_word;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op        <= '0;
            r_addr_lo   <= '0;
            r_wdata     <= '0;
            r_rd_word   <= '0;
            r_cnt       <= '0;
            r_fail      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_lsu_rdata <= '0;
            r_lsu_done  <= 1'b0;
            r_lsu_busy  <= 1'b0;
            r_lsu_err   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_mem_req  <= (w_next == RD) || (w_next == WR);
            r_mem_we   <= (w_next == WR);
            r_lsu_busy <= (w_next != IDLE);
            r_lsu_done <= (r_state == RESP);
            r_lsu_err  <= (r_state == RESP) && r_fail;

            if ((w_next == RD || w_next == WR) && (w_next != r_state))
                r_cnt <= '0;
            else if ((r_state == RD || r_state == WR) && (r_cnt != CW'(WAIT_MAX)))
                r_cnt <= r_cnt + 1'b1;

            case (r_state)
                IDLE: begin
                    if (lsu_req) begin
                        r_op       <= lsu_op;
                        r_addr_lo  <= lsu_addr[1:0];
                        r_wdata    <= lsu_wdata[15:0];
                        r_fail     <= (w_next == RESP);
                        r_mem_addr <= {lsu_addr[`CPU_WIDTH-1:2], 2'b00};
                        if (w_next == WR)
                            r_mem_wdata <= lsu_wdata;
                    end
                end
                RD: begin
                    if (mem_ack) begin
                        if (r_op[3])
                            r_mem_wdata <= w_merge;
                        else
                            r_rd_word <= mem_rdata;
                    end else if (w_timeout) begin
                        r_fail <= 1'b1;
                    end
                end
                WR: begin
                    if (w_timeout)
                        r_fail <= 1'b1;
                end
                RESP: begin
                    if (!r_fail && !r_op[3])
                        r_lsu_rdata <= w_load;
                end
                default: ;
            endcase
        end
    end

    assign lsu_rdata = r_lsu_rdata;
    assign lsu_done  = r_lsu_done;
    assign lsu_busy  = r_lsu_busy;
    assign lsu_err   = r_lsu_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: vector table of single accesses plus timeout, reset-abort
// and stray-ack sequences. Honours MEM_MISALIGN_CHK_EN for the misaligned rows.

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef MEM_OP_WIDTH
`define MEM_OP_WIDTH 4
`define MEM_LB  4'h0
`define MEM_LH  4'h1
`define MEM_LW  4'h2
`define MEM_LBU 4'h4
`define MEM_LHU 4'h5
`define MEM_SB  4'h8
`define MEM_SH  4'h9
`define MEM_SW  4'hA
`endif

module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_req;
    logic [3:0]  lsu_op;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [31:0] lsu_rdata;
    logic        lsu_done;
    logic        lsu_busy;
    logic        lsu_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_ctrl #(.WAIT_MAX(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .lsu_req   (lsu_req),
        .lsu_op    (lsu_op),
        .lsu_addr  (lsu_addr),
        .lsu_wdata (lsu_wdata),
        .lsu_rdata (lsu_rdata),
        .lsu_done  (lsu_done),
        .lsu_busy  (lsu_busy),
        .lsu_err   (lsu_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mword;
        logic [31:0] exp_rd;
        logic [31:0] exp_wd;
        logic [31:0] exp_ma;
        int          exp_lat;
        int          exp_nrd;
        int          exp_nwr;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issues one request and plays the memory; lat counts cycles from the accept cycle.
    task automatic do_access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] mw, input bit ack_en,
                             output int lat, output int reqc, output int nrd, output int nwr,
                             output logic [31:0] wr_d, output logic [31:0] ma,
                             output logic [31:0] rd, output logic err, output logic done_after);
        bit seen = 0;
        lat = 0; reqc = 0; nrd = 0; nwr = 0; wr_d = '0; ma = '0; rd = '0; err = 1'b0;
        @(negedge clk);
        lsu_req = 1'b1; lsu_op = op; lsu_addr = addr; lsu_wdata = wd; mem_ack = 1'b0;
        @(negedge clk);
        lsu_req = 1'b0;
        for (int c = 1; c < 40 && !seen; c++) begin
            if (lsu_done) begin
                seen = 1; lat = c; rd = lsu_rdata; err = lsu_err; mem_ack = 1'b0;
            end else begin
                if (mem_req) begin
                    reqc++;
                    if (reqc == 1) ma = mem_addr;
                    mem_rdata = mw;
                    mem_ack   = ack_en;
                    if (ack_en) begin
                        if (mem_we) begin nwr++; wr_d = mem_wdata; end
                        else nrd++;
                    end
                end else begin
                    mem_ack = 1'b0;
                end
                @(negedge clk);
            end
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL done_timeout: got no lsu_done expected lsu_done within 39 cycles");
        end
        @(negedge clk);
        done_after = lsu_done;
    endtask

    initial begin
        int          lat, reqc, nrd, nwr;
        logic [31:0] wr_d, ma, rd;
        logic        err, done_after;
        logic [31:0] last_load;

        vecs[0]  = '{`MEM_LW,  32'h104, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h104, 3, 1, 0, 1'b0};
        vecs[1]  = '{`MEM_SB,  32'h202, 32'h000000AA, 32'h11223344, 32'h0,        32'h11AA3344, 32'h200, 4, 1, 1, 1'b0};
        vecs[2]  = '{`MEM_LB,  32'h003, 32'h0,        32'h80FFFFFF, 32'hFFFFFF80, 32'h0,        32'h000, 3, 1, 0, 1'b0};
        vecs[3]  = '{`MEM_LBU, 32'h003, 32'h0,        32'h80FFFFFF, 32'h00000080, 32'h0,        32'h000, 3, 1, 0, 1'b0};
        vecs[4]  = '{`MEM_LH,  32'h102, 32'h0,        32'h80017FFF, 32'hFFFF8001, 32'h0,        32'h100, 3, 1, 0, 1'b0};
        vecs[5]  = '{`MEM_LHU, 32'h102, 32'h0,        32'h80017FFF, 32'h00008001, 32'h0,        32'h100, 3, 1, 0, 1'b0};
        vecs[6]  = '{`MEM_SH,  32'h102, 32'h1234BEEF, 32'hAAAAAAAA, 32'h0,        32'hBEEFAAAA, 32'h100, 4, 1, 1, 1'b0};
        vecs[7]  = '{`MEM_SW,  32'h10C, 32'hCAFEF00D, 32'h55555555, 32'h0,        32'hCAFEF00D, 32'h10C, 3, 0, 1, 1'b0};
        vecs[8]  = '{`MEM_SB,  32'h201, 32'hFFFFFF55, 32'h11223344, 32'h0,        32'h11225544, 32'h200, 4, 1, 1, 1'b0};
        vecs[9]  = '{`MEM_LB,  32'h000, 32'h0,        32'h0000007F, 32'h0000007F, 32'h0,        32'h000, 3, 1, 0, 1'b0};
`ifdef MEM_MISALIGN_CHK_EN
        vecs[10] = '{`MEM_SH,  32'h101, 32'h0000BEEF, 32'h11223344, 32'h0,        32'h0,        32'h0,   2, 0, 0, 1'b1};
        vecs[11] = '{`MEM_LW,  32'h105, 32'h0,        32'h0BADF00D, 32'h0,        32'h0,        32'h0,   2, 0, 0, 1'b1};
`else
        vecs[10] = '{`MEM_SH,  32'h101, 32'h0000BEEF, 32'h11223344, 32'h0,        32'h1122BEEF, 32'h100, 4, 1, 1, 1'b0};
        vecs[11] = '{`MEM_LW,  32'h105, 32'h0,        32'h0BADF00D, 32'h0BADF00D, 32'h0,        32'h104, 3, 1, 0, 1'b0};
`endif

        rst = 1'b1; lsu_req = 1'b0; lsu_op = '0; lsu_addr = '0; lsu_wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {28'b0, mem_req, mem_we, lsu_done, lsu_busy}, 32'h0);
        check("reset_err", {31'b0, lsu_err}, 32'h0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_mem_wdata", mem_wdata, 32'h0);
        check("reset_rdata", lsu_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        last_load = 32'h0;
        for (int i = 0; i < 12; i++) begin
            do_access(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].mword, 1'b1,
                      lat, reqc, nrd, nwr, wr_d, ma, rd, err, done_after);
            if (!vecs[i].op[3] && !vecs[i].exp_err) last_load = vecs[i].exp_rd;
            check($sformatf("row%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("row%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
            check($sformatf("row%0d_rdata", i), rd, last_load);
            check($sformatf("row%0d_reads", i), nrd, vecs[i].exp_nrd);
            check($sformatf("row%0d_writes", i), nwr, vecs[i].exp_nwr);
            check($sformatf("row%0d_req_cycles", i), reqc, vecs[i].exp_nrd + vecs[i].exp_nwr);
            check($sformatf("row%0d_done_width", i), {31'b0, done_after}, 32'h0);
            if (vecs[i].exp_nrd + vecs[i].exp_nwr > 0)
                check($sformatf("row%0d_mem_addr", i), ma, vecs[i].exp_ma);
            if (vecs[i].exp_nwr > 0)
                check($sformatf("row%0d_wdata", i), wr_d, vecs[i].exp_wd);
        end

        // Ack timeout on a load.
        do_access(`MEM_LW, 32'h300, 32'h0, 32'h12345678, 1'b0,
                  lat, reqc, nrd, nwr, wr_d, ma, rd, err, done_after);
        check("timeout_req_cycles", reqc, 15);
        check("timeout_latency", lat, 17);
        check("timeout_err", {31'b0, err}, 32'h1);
        check("timeout_rdata_hold", rd, last_load);
        check("timeout_done_width", {31'b0, done_after}, 32'h0);

        // Stray ack while idle.
        @(negedge clk);
        mem_ack = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ack_ignored", {29'b0, mem_req, lsu_busy, lsu_done}, 32'h0);
        mem_ack = 1'b0;

        // Reset during the write phase of SB.
        @(negedge clk);
        lsu_req = 1'b1; lsu_op = `MEM_SB; lsu_addr = 32'h202; lsu_wdata = 32'hAA;
        @(negedge clk);
        lsu_req = 1'b0;
        check("rst_seq_rd_phase", {30'b0, mem_req, mem_we}, 32'h2);
        mem_rdata = 32'h11223344; mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("rst_seq_wr_phase", {30'b0, mem_req, mem_we}, 32'h3);
        #2 rst = 1'b1;
        #1 check("rst_seq_abort", {29'b0, mem_req, mem_we, lsu_busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int n_done = 0;
            repeat (5) begin
                @(negedge clk);
                if (lsu_done) n_done++;
            end
            check("rst_seq_no_done", n_done, 0);
        end
        do_access(`MEM_SW, 32'h400, 32'h0F0F0F0F, 32'h0, 1'b1,
                  lat, reqc, nrd, nwr, wr_d, ma, rd, err, done_after);
        check("post_rst_sw_latency", lat, 3);
        check("post_rst_sw_wdata", wr_d, 32'h0F0F0F0F);
        check("post_rst_sw_addr", ma, 32'h400);
        check("post_rst_sw_err", {31'b0, err}, 32'h0);
        check("post_rst_rdata_cleared", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_MAX, default 15, meaning max cycles one memory phase waits for mem_ack before timeout.
REQ-002 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port lsu_req  input  1  CPU access request, sampled only in IDLE.
REQ-005 The block SHALL have port lsu_op  input  `MEM_OP_WIDTH  opcode, one of `MEM_LB/LH/LW/LBU/LHU/SB/SH/SW.
REQ-006 The block SHALL have port lsu_addr  input  `CPU_WIDTH  byte address.
REQ-007 The block SHALL have port lsu_wdata  input  `CPU_WIDTH  store data (rs2).
REQ-008 The block SHALL have port lsu_rdata  output  `CPU_WIDTH  load result, sign/zero extended.
REQ-009 The block SHALL have port lsu_done  output  1  one-cycle completion pulse.
REQ-010 The block SHALL have port lsu_busy  output  1  high while not IDLE.
REQ-011 The block SHALL have port lsu_err  output  1  error flag, valid with lsu_done.
REQ-012 The block SHALL have ports mem_req/mem_we  output  1 each, mem_addr/mem_wdata  output  `CPU_WIDTH, mem_rdata  input  `CPU_WIDTH, mem_ack  input  1  word-wide memory port.

Function
REQ-013 FSM states SHALL be IDLE, RD, WR, RESP; all outputs registered.
REQ-014 IDLE with lsu_req=1: load or SB/SH -> RD; SW -> WR; operands latched; lsu_req ignored outside IDLE.
REQ-015 In RD/WR mem_req SHALL be 1, mem_addr = {addr[31:2],2'b00}, mem_we = 1 only in WR.
REQ-016 RD with mem_ack: load -> RESP with rdata captured; SB/SH -> WR with merged word registered.
REQ-017 Merge: SB replaces byte lane addr[1:0] of mem_rdata with wdata[7:0]; SH replaces halfword lane addr[1] with wdata[15:0]; SW writes wdata unchanged.
REQ-018 Load extraction: LB/LBU select byte addr[1:0], LH/LHU select halfword addr[1], sign- or zero-extended to `CPU_WIDTH; LW whole word.
REQ-019 WR with mem_ack -> RESP; RESP asserts lsu_done=1 for exactly one cycle then -> IDLE.
REQ-020 Latency with mem_ack in first request cycle: load/SW done 3 cycles after lsu_req accepted, SB/SH 4 cycles.
REQ-021 A per-phase counter SHALL clear on entering RD/WR; when it reaches WAIT_MAX without mem_ack, mem_req drops, -> RESP with lsu_err=1, no write issued.
REQ-022 mem_ack outside RD/WR SHALL be ignored; lsu_rdata SHALL hold last load value until next load completes.

Reset
REQ-023 rst=1 SHALL force IDLE asynchronously; mem_req, mem_we, lsu_done, lsu_busy, lsu_err = 0; mem_addr, mem_wdata, lsu_rdata, counter = 0.
REQ-024 Reset mid-access SHALL abort it with no done pulse; first request after release starts a fresh access.

Configuration
REQ-025 With MEM_MISALIGN_CHK_EN defined: LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 SHALL go IDLE -> RESP with lsu_err=1, no mem_req.
REQ-026 Without MEM_MISALIGN_CHK_EN: low address bits not used for lane selection SHALL be ignored, access proceeds normally, lsu_err set only by timeout.

Verification
REQ-027 LW addr 0x104, mem_rdata 0xDEADBEEF, immediate ack -> mem_addr 0x104, lsu_rdata 0xDEADBEEF, done 3 cycles after accept.
REQ-028 SB addr 0x202, wdata 0x000000AA, read returns 0x11223344 -> one read then one write of 0x11AA3344 at 0x200, done 4 cycles after accept.
REQ-029 LB addr 0x3, mem_rdata 0x80FFFFFF -> lsu_rdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-030 LW with mem_ack never asserted, WAIT_MAX=15 -> mem_req drops after 15 cycles, lsu_done=1 with lsu_err=1.
REQ-031 SH addr 0x101: macro defined -> lsu_err=1, no mem_req; undefined -> write lands in halfword lane 0 of 0x100.
REQ-032 rst pulsed during WR of SB -> mem_req=0 immediately, no lsu_done; next SW completes normally.
